// File: rtl/vga_pong.sv
// 640x480@60 VGA source: sync generation plus a monochrome pong scene
// (borders, dashed net, two self-bouncing paddles) on twelve 1-bit colour pins.
module vga_pong (
    input  logic clk,
    input  logic rst,
    output logic r0,
    output logic r1,
    output logic r2,
    output logic r3,
    output logic g0,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic b0,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic hs,
    output logic vs
);
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [8:0] POS_TOP = 9'd8;
    localparam logic [8:0] POS_BOT = 9'd408;

    logic [9:0] count_h_q, count_h_d;
    logic [9:0] count_v_q, count_v_d;
    logic [8:0] pos_l_q, pos_l_d;
    logic [8:0] pos_r_q, pos_r_d;
    logic       dir_l_q, dir_l_d;
    logic       dir_r_q, dir_r_d;
    logic       frame_end;
    logic       blank, border, net, pad_l, pad_r, wht, pix;

    // Returns {dir, pos}; the upward case is tested before subtracting so it never wraps.
    function automatic logic [9:0] bounce(input logic [8:0] pos, input logic down,
                                          input logic [9:0] step);
        logic [9:0] nxt;
        nxt = {1'b0, pos} + step;
        if (down) begin
            if (nxt > {1'b0, POS_BOT}) bounce = {1'b0, POS_BOT};
            else                       bounce = {1'b1, nxt[8:0]};
        end else begin
            nxt = {1'b0, pos} - step;
            if ({1'b0, pos} < step + {1'b0, POS_TOP}) bounce = {1'b1, POS_TOP};
            else                                       bounce = {1'b0, nxt[8:0]};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_h_q <= '0;
            count_v_q <= '0;
            pos_l_q   <= POS_TOP;
            dir_l_q   <= 1'b1;
            pos_r_q   <= POS_BOT;
            dir_r_q   <= 1'b0;
        end else begin
            count_h_q <= count_h_d;
            count_v_q <= count_v_d;
            pos_l_q   <= pos_l_d;
            dir_l_q   <= dir_l_d;
            pos_r_q   <= pos_r_d;
            dir_r_q   <= dir_r_d;
        end
    end

    always_comb begin
        frame_end = (count_h_q == H_LAST) && (count_v_q == V_LAST);
        count_h_d = (count_h_q == H_LAST) ? 10'd0 : count_h_q + 10'd1;
        count_v_d = count_v_q;
        if (count_h_q == H_LAST)
            count_v_d = (count_v_q == V_LAST) ? 10'd0 : count_v_q + 10'd1;
        {dir_l_d, pos_l_d} = {dir_l_q, pos_l_q};
        {dir_r_d, pos_r_d} = {dir_r_q, pos_r_q};
        // Positions only move on the last pixel of a frame, so nothing tears.
        if (frame_end) begin
            {dir_l_d, pos_l_d} = bounce(pos_l_q, dir_l_q, 10'd2);
            {dir_r_d, pos_r_d} = bounce(pos_r_q, dir_r_q, 10'd3);
        end
    end

    always_comb begin
        blank  = (count_h_q >= 10'd640) || (count_v_q >= 10'd480);
        border = (count_v_q <= 10'd7) || ((count_v_q >= 10'd472) && (count_v_q <= 10'd479));
        net    = (count_h_q >= 10'd316) && (count_h_q <= 10'd323) &&
                 (count_v_q >= 10'd8) && (count_v_q <= 10'd471) && !count_v_q[4];
        pad_l  = (count_h_q >= 10'd16) && (count_h_q <= 10'd23) &&
                 (count_v_q >= {1'b0, pos_l_q}) && (count_v_q <= {1'b0, pos_l_q} + 10'd63);
        pad_r  = (count_h_q >= 10'd616) && (count_h_q <= 10'd623) &&
                 (count_v_q >= {1'b0, pos_r_q}) && (count_v_q <= {1'b0, pos_r_q} + 10'd63);
        wht    = border | net | pad_l | pad_r;
        pix    = wht & ~blank & rst;
        {r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3} = {12{pix}};
        hs     = ~rst | ~((count_h_q >= 10'd656) && (count_h_q <= 10'd751));
        vs     = ~rst | ~((count_v_q >= 10'd490) && (count_v_q <= 10'd491));
    end
endmodule

// File: tb/tb_vga_pong.sv
// Bench for vga_pong: fixed pixel table, timing sequences, paddle bounce and
// randomized counter positions checked against a rule-level scene model.
module tb_vga_pong;
    logic clk, rst;
    logic r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3, hs, vs;
    int checks = 0, errors = 0;
    int mh, mv, ml, mr;
    bit mdl, mdr;
    logic [9:0] fh, fv;

    typedef struct { int h; int v; bit w; bit hs; bit vs; } vec_t;
    vec_t tbl[$];

    vga_pong dut (
        .clk(clk), .rst(rst),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .g0(g0), .g1(g1), .g2(g2), .g3(g3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .hs(hs), .vs(vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int col_bus();
        return int'({r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3});
    endfunction

    function automatic bit mwhite(int h, int v, int pl, int pr);
        bit border, net, lp, rp;
        border = (v <= 7) || (v >= 472 && v <= 479);
        net    = (h >= 316 && h <= 323 && v >= 8 && v <= 471 && ((v / 16) % 2 == 0));
        lp     = (h >= 16 && h <= 23 && v >= pl && v <= pl + 63);
        rp     = (h >= 616 && h <= 623 && v >= pr && v <= pr + 63);
        return (h < 640) && (v < 480) && (border || net || lp || rp);
    endfunction

    task automatic mmove(inout int pos, inout bit down, input int step);
        int nxt;
        nxt = down ? pos + step : pos - step;
        if (nxt > 408)    begin pos = 408; down = 1'b0; end
        else if (nxt < 8) begin pos = 8;   down = 1'b1; end
        else              pos = nxt;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", name, act, exp, mh, mv);
        end
    endtask

    task automatic check_out(input string name);
        chk({name, "_col"}, col_bus(), (rst && mwhite(mh, mv, ml, mr)) ? 12'hFFF : 0);
        chk({name, "_hs"}, int'(hs), (!rst || !(mh >= 656 && mh <= 751)) ? 1 : 0);
        chk({name, "_vs"}, int'(vs), (!rst || !(mv >= 490 && mv <= 491)) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            mh = 0; mv = 0; ml = 8; mdl = 1'b1; mr = 408; mdr = 1'b0;
        end else begin
            if (mh == 799 && mv == 524) begin
                mmove(ml, mdl, 2);
                mmove(mr, mdr, 3);
            end
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 524) ? 0 : mv + 1;
            end else mh++;
        end
        #1;
    endtask

    // Deposit a raster position into the counters; the value holds until the next edge.
    task automatic set_cnt(input int h, input int v);
        @(negedge clk);
        fh = 10'(h); fv = 10'(v);
        force dut.count_h_q = fh;
        force dut.count_v_q = fv;
        #1;
        release dut.count_h_q;
        release dut.count_v_q;
        mh = h; mv = v;
    endtask

    task automatic skip_frame();
        set_cnt(799, 524);
        tick();
        chk("pos_l", int'(dut.pos_l_q), ml);
        chk("pos_r", int'(dut.pos_r_q), mr);
        chk("dir_l", int'(dut.dir_l_q), int'(mdl));
        chk("dir_r", int'(dut.dir_r_q), int'(mdr));
    endtask

    initial begin
        int fall_h, rise_h, vlow, vstart_h, vstart_v;
        bit prev;
        rst = 1'b0;
        mh = 0; mv = 0; ml = 8; mdl = 1'b1; mr = 408; mdr = 1'b0;

        // Reset held for 4 clocks
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_col", col_bus(), 0);
            chk("rst_hs", int'(hs), 1);
            chk("rst_vs", int'(vs), 1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("first_h", int'(dut.count_h_q), 0);
        chk("first_v", int'(dut.count_v_q), 0);
        chk("first_col", col_bus(), 12'hFFF);

        // Fixed pixel table with paddles at their reset positions (8 and 408)
        tbl.push_back('{0, 0, 1, 1, 1});     tbl.push_back('{639, 0, 1, 1, 1});
        tbl.push_back('{640, 0, 0, 1, 1});   tbl.push_back('{20, 40, 1, 1, 1});
        tbl.push_back('{20, 71, 1, 1, 1});   tbl.push_back('{20, 72, 0, 1, 1});
        tbl.push_back('{15, 40, 0, 1, 1});   tbl.push_back('{24, 40, 0, 1, 1});
        tbl.push_back('{620, 408, 1, 1, 1}); tbl.push_back('{620, 407, 0, 1, 1});
        tbl.push_back('{616, 450, 1, 1, 1}); tbl.push_back('{624, 450, 0, 1, 1});
        tbl.push_back('{320, 8, 1, 1, 1});   tbl.push_back('{320, 16, 0, 1, 1});
        tbl.push_back('{316, 47, 1, 1, 1});  tbl.push_back('{323, 32, 1, 1, 1});
        tbl.push_back('{324, 32, 0, 1, 1});  tbl.push_back('{320, 100, 1, 1, 1});
        tbl.push_back('{320, 120, 0, 1, 1}); tbl.push_back('{320, 472, 1, 1, 1});
        tbl.push_back('{100, 479, 1, 1, 1}); tbl.push_back('{100, 480, 0, 1, 1});
        tbl.push_back('{655, 100, 0, 1, 1}); tbl.push_back('{656, 100, 0, 0, 1});
        tbl.push_back('{751, 100, 0, 0, 1}); tbl.push_back('{752, 100, 0, 1, 1});
        tbl.push_back('{100, 489, 0, 1, 1}); tbl.push_back('{100, 490, 0, 1, 0});
        tbl.push_back('{700, 491, 0, 0, 0}); tbl.push_back('{100, 492, 0, 1, 1});
        foreach (tbl[i]) begin
            set_cnt(tbl[i].h, tbl[i].v);
            chk("tbl_col", col_bus(), tbl[i].w ? 12'hFFF : 0);
            chk("tbl_hs", int'(hs), int'(tbl[i].hs));
            chk("tbl_vs", int'(vs), int'(tbl[i].vs));
        end

        // One full line from (799,99): hs edges and blanking every cycle
        set_cnt(799, 99);
        fall_h = -1; rise_h = -1; prev = hs;
        for (int i = 0; i < 800; i++) begin
            tick();
            check_out("line");
            if (prev && !hs && fall_h < 0) fall_h = mh;
            if (!prev && hs && rise_h < 0) rise_h = mh;
            prev = hs;
        end
        chk("hs_fall_h", fall_h, 656);
        chk("hs_rise_h", rise_h, 752);

        // Vertical sync window
        set_cnt(799, 488);
        vlow = 0; vstart_h = -1; vstart_v = -1;
        for (int i = 0; i < 3300; i++) begin
            tick();
            check_out("vert");
            if (!vs) begin
                if (vlow == 0) begin vstart_h = mh; vstart_v = mv; end
                vlow++;
            end
        end
        chk("vs_low_cycles", vlow, 1600);
        chk("vs_start_h", vstart_h, 0);
        chk("vs_start_v", vstart_v, 490);

        // First paddle step
        skip_frame();
        chk("step1_pos_l", int'(dut.pos_l_q), 10);
        chk("step1_pos_r", int'(dut.pos_r_q), 405);
        set_cnt(20, 10); chk("pix_20_10", col_bus(), 12'hFFF);
        set_cnt(20, 73); chk("pix_20_73", col_bus(), 12'hFFF);
        set_cnt(20, 74); chk("pix_20_74", col_bus(), 0);

        // Bounce: frames 2..202
        for (int f = 2; f <= 202; f++) begin
            skip_frame();
            if (f == 134) chk("bounce_r134", int'(dut.pos_r_q), 8);
            if (f == 135) chk("bounce_r135", int'(dut.pos_r_q), 11);
            if (f == 200) chk("bounce_l200", int'(dut.pos_l_q), 408);
            if (f == 201) chk("bounce_l201_dir", int'(dut.dir_l_q), 0);
            if (f == 202) chk("bounce_l202", int'(dut.pos_l_q), 406);
        end

        // Randomized raster positions and paddle states
        for (int i = 0; i < 150; i++) begin
            int nf;
            nf = $urandom_range(0, 4);
            for (int k = 0; k < nf; k++) skip_frame();
            if ($urandom_range(0, 3) == 0)
                set_cnt($urandom_range(0, 799), $urandom_range(0, 524));
            else
                set_cnt($urandom_range(0, 30) + ($urandom_range(0, 1) ? 0 : 600),
                        ml + $urandom_range(0, 70) - 3);
            check_out("rnd");
            for (int k = 0; k < 3; k++) begin
                tick();
                check_out("rnd_run");
            end
        end

        // Mid-frame reset
        set_cnt(123, 300);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_out("mid_rst_async");
        tick();
        chk("mid_rst_h", int'(dut.count_h_q), 0);
        chk("mid_rst_v", int'(dut.count_v_q), 0);
        chk("mid_rst_pos_l", int'(dut.pos_l_q), 8);
        chk("mid_rst_pos_r", int'(dut.pos_r_q), 408);
        chk("mid_rst_dir_l", int'(dut.dir_l_q), 1);
        chk("mid_rst_dir_r", int'(dut.dir_r_q), 0);
        check_out("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("after_rst");
        chk("after_rst_col", col_bus(), 12'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
